// File: rtl/bomb_game_pkg.sv
// rtl/bomb_game_pkg.sv - shared types, widths and LFSR tap table for the bomb game sequencer
//
// Contents:
//   game_state_e  sequencer states
//   SEC_W         width of the seconds counter
//   LIVES_W       width of the lives counter
//   LFSR_MAX_W    widest supported LFSR
//   lfsr_taps()   maximal-length feedback tap mask for a given LFSR width
package bomb_game_pkg;

  typedef enum logic [2:0] {
    ST_OFF     = 3'd0,
    ST_IDLE    = 3'd1,
    ST_SHOW    = 3'd2,
    ST_INPUT   = 3'd3,
    ST_FAIL    = 3'd4,
    ST_SUCCESS = 3'd5
  } game_state_e;

  localparam int unsigned SEC_W      = 8;
  localparam int unsigned LIVES_W    = 3;
  localparam int unsigned LFSR_MAX_W = 16;

  // Bit (n-1) set means stage n is tapped. Each mask is a primitive
  // polynomial, so a non-zero register cycles through all 2^w-1 states.
  function automatic logic [LFSR_MAX_W-1:0] lfsr_taps(input int unsigned w);
    logic [LFSR_MAX_W-1:0] taps;
    case (w)
      2:       taps = 16'h0003;
      3:       taps = 16'h0006;
      4:       taps = 16'h000C;
      5:       taps = 16'h0014;
      6:       taps = 16'h0030;
      7:       taps = 16'h0060;
      8:       taps = 16'h00B8;
      9:       taps = 16'h0110;
      10:      taps = 16'h0240;
      11:      taps = 16'h0500;
      12:      taps = 16'h0829;
      13:      taps = 16'h100D;
      14:      taps = 16'h2015;
      15:      taps = 16'h6000;
      16:      taps = 16'hD008;
      default: taps = 16'h0000;
    endcase
    return taps;
  endfunction

endpackage

// File: rtl/lfsr_gen.sv
// rtl/lfsr_gen.sv - free-running Fibonacci LFSR used as the round code source
//
// Ports:
//   clk   in   system clock
//   Rst   in   synchronous reset, active-low (loads SEED)
//   adv   in   advance one step this cycle
//   q     out  current LFSR value, W bits, never all-zero
module lfsr_gen
  import bomb_game_pkg::*;
#(
  parameter int unsigned    W    = 5,
  parameter logic [W-1:0]   SEED = {{(W-1){1'b0}}, 1'b1}
) (
  input  logic         clk,
  input  logic         Rst,
  input  logic         adv,
  output logic [W-1:0] q
);

  localparam logic [LFSR_MAX_W-1:0] TAPS_ALL = lfsr_taps(W);
  localparam logic [W-1:0]          TAPS     = TAPS_ALL[W-1:0];

  if (W < 2 || W > LFSR_MAX_W) begin : g_bad_width
    $error("lfsr_gen: W must be in 2..16");
  end
  if (SEED == '0) begin : g_bad_seed
    $error("lfsr_gen: SEED must be non-zero");
  end

  logic [W-1:0] lfsr_q;
  logic [W-1:0] lfsr_d;
  logic         feedback;

  always_comb begin
    feedback = ^(lfsr_q & TAPS);
    lfsr_d   = adv ? {lfsr_q[W-2:0], feedback} : lfsr_q;
  end

  always_ff @(posedge clk) begin
    if (!Rst) begin
      lfsr_q <= SEED;
    end else begin
      lfsr_q <= lfsr_d;
    end
  end

  assign q = lfsr_q;

endmodule

// File: rtl/bomb_game_ctrl.sv
// rtl/bomb_game_ctrl.sv - game sequencer: gates display/timer/entry blocks, latches the round code
//
// Ports:
//   clk          in   system clock
//   Rst          in   synchronous reset, active-low
//   enable       in   master switch level
//   btn_start    in   debounced start button level
//   tick_1hz     in   one-cycle pulse per second
//   code_ok      in   one-cycle pulse, correct code entered
//   code_bad     in   one-cycle pulse, wrong code entered
//   bomb_en      out  bomb matrix display enable
//   showing      out  code display enable
//   start        out  countdown display enable
//   start_input  out  code-entry block enable
//   random       out  code latched for the current round
//   sec_left     out  seconds remaining in the current phase
//   lives        out  remaining lives
//   sub_rst_n    out  one-cycle active-low reset to sub-blocks
//   fail         out  high in FAIL
//   success      out  high in SUCCESS
module bomb_game_ctrl
  import bomb_game_pkg::*;
#(
  parameter int unsigned       CODE_W       = 5,
  parameter logic [CODE_W-1:0] SEED         = 5'b10101,
  parameter int unsigned       SHOW_SEC     = 5,
  parameter int unsigned       COUNT_SEC    = 20,
  parameter int unsigned       HOLD_SEC     = 3,
  parameter int unsigned       MAX_LIVES    = 3,
  parameter int unsigned       AUTO_RESTART = 1
) (
  input  logic               clk,
  input  logic               Rst,
  input  logic               enable,
  input  logic               btn_start,
  input  logic               tick_1hz,
  input  logic               code_ok,
  input  logic               code_bad,
  output logic               bomb_en,
  output logic               showing,
  output logic               start,
  output logic               start_input,
  output logic [CODE_W-1:0]  random,
  output logic [SEC_W-1:0]   sec_left,
  output logic [LIVES_W-1:0] lives,
  output logic               sub_rst_n,
  output logic               fail,
  output logic               success
);

  if (CODE_W < 2 || CODE_W > 16) begin : g_bad_code_w
    $error("bomb_game_ctrl: CODE_W must be in 2..16");
  end
  if (SHOW_SEC > 255 || COUNT_SEC > 255 || HOLD_SEC > 255) begin : g_bad_sec
    $error("bomb_game_ctrl: second counts must fit in 8 bits");
  end
  if (MAX_LIVES < 1 || MAX_LIVES > 7) begin : g_bad_lives
    $error("bomb_game_ctrl: MAX_LIVES must be in 1..7");
  end

  localparam logic [SEC_W-1:0]   SHOW_L  = SHOW_SEC[SEC_W-1:0];
  localparam logic [SEC_W-1:0]   COUNT_L = COUNT_SEC[SEC_W-1:0];
  localparam logic [SEC_W-1:0]   HOLD_L  = HOLD_SEC[SEC_W-1:0];
  localparam logic [SEC_W-1:0]   ONE_SEC = SEC_W'(1);
  localparam logic [LIVES_W-1:0] MAX_L   = MAX_LIVES[LIVES_W-1:0];
  localparam logic [LIVES_W-1:0] ONE_L   = LIVES_W'(1);
  localparam logic               AUTO_L  = (AUTO_RESTART != 0);

  game_state_e        state_q, state_d;
  logic               btn_start_q;
  logic               enable_q;
  logic [CODE_W-1:0]  random_q, random_d;
  logic [SEC_W-1:0]   sec_q, sec_d;
  logic [LIVES_W-1:0] lives_q, lives_d;
  logic               bomb_en_q, bomb_en_d;
  logic               showing_q, showing_d;
  logic               start_q, start_d;
  logic               start_input_q, start_input_d;
  logic               sub_rst_n_q, sub_rst_n_d;
  logic               fail_q, fail_d;
  logic               success_q, success_d;

  logic               start_edge;
  logic               lfsr_adv;
  logic [CODE_W-1:0]  lfsr_q;

  assign lfsr_adv = (state_q != ST_OFF);

  lfsr_gen #(
    .W    (CODE_W),
    .SEED (SEED)
  ) u_lfsr (
    .clk (clk),
    .Rst (Rst),
    .adv (lfsr_adv),
    .q   (lfsr_q)
  );

  always_ff @(posedge clk) begin
    if (!Rst) begin
      state_q       <= ST_OFF;
      btn_start_q   <= 1'b0;
      enable_q      <= 1'b0;
      random_q      <= SEED;
      sec_q         <= '0;
      lives_q       <= MAX_L;
      bomb_en_q     <= 1'b0;
      showing_q     <= 1'b0;
      start_q       <= 1'b0;
      start_input_q <= 1'b0;
      sub_rst_n_q   <= 1'b1;
      fail_q        <= 1'b0;
      success_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      btn_start_q   <= btn_start;
      enable_q      <= enable;
      random_q      <= random_d;
      sec_q         <= sec_d;
      lives_q       <= lives_d;
      bomb_en_q     <= bomb_en_d;
      showing_q     <= showing_d;
      start_q       <= start_d;
      start_input_q <= start_input_d;
      sub_rst_n_q   <= sub_rst_n_d;
      fail_q        <= fail_d;
      success_q     <= success_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    random_d   = random_q;
    sec_d      = sec_q;
    lives_d    = lives_q;
    start_edge = btn_start & ~btn_start_q;

    if (state_q != ST_OFF && !enable) begin
      state_d = ST_OFF;
    end else begin
      case (state_q)
        ST_OFF: begin
          if (enable) state_d = ST_IDLE;
        end

        ST_IDLE: begin
          if (start_edge) begin
            random_d = lfsr_q;
            sec_d    = SHOW_L;
            state_d  = ST_SHOW;
          end
        end

        ST_SHOW: begin
          if (tick_1hz) begin
            // <= covers a zero SHOW_SEC without wrapping the counter
            if (sec_q <= ONE_SEC) begin
              sec_d   = COUNT_L;
              state_d = ST_INPUT;
            end else begin
              sec_d = sec_q - ONE_SEC;
            end
          end
        end

        ST_INPUT: begin
          // code_ok beats code_bad and timer expiry; code_bad beats the tick
          if (code_ok) begin
            sec_d   = HOLD_L;
            state_d = ST_SUCCESS;
          end else if (code_bad) begin
            if (lives_q > ONE_L) begin
              lives_d = lives_q - ONE_L;
            end else begin
              lives_d = '0;
              sec_d   = HOLD_L;
              state_d = ST_FAIL;
            end
          end else if (tick_1hz) begin
            if (sec_q <= ONE_SEC) begin
              sec_d   = HOLD_L;
              state_d = ST_FAIL;
            end else begin
              sec_d = sec_q - ONE_SEC;
            end
          end
        end

        ST_FAIL, ST_SUCCESS: begin
          // Zero means the hold has expired and we are waiting for a start press
          if (sec_q == '0) begin
            if (start_edge) state_d = ST_IDLE;
          end else if (tick_1hz) begin
            sec_d = sec_q - ONE_SEC;
            if (sec_q == ONE_SEC && AUTO_L) state_d = ST_IDLE;
          end
        end

        default: state_d = ST_OFF;
      endcase
    end

    if (state_d == ST_IDLE) lives_d = MAX_L;
  end

  // Output flags are decoded from the next state so they line up with state_q
  always_comb begin
    bomb_en_d     = (state_d == ST_SHOW) || (state_d == ST_INPUT);
    showing_d     = (state_d == ST_SHOW) || (state_d == ST_SUCCESS);
    start_d       = (state_d == ST_INPUT);
    start_input_d = (state_d == ST_INPUT);
    fail_d        = (state_d == ST_FAIL);
    success_d     = (state_d == ST_SUCCESS);
    sub_rst_n_d   = !(((state_d == ST_IDLE) && (state_q != ST_IDLE)) ||
                      (enable_q && !enable));
  end

  assign bomb_en     = bomb_en_q;
  assign showing     = showing_q;
  assign start       = start_q;
  assign start_input = start_input_q;
  assign random      = random_q;
  assign sec_left    = sec_q;
  assign lives       = lives_q;
  assign sub_rst_n   = sub_rst_n_q;
  assign fail        = fail_q;
  assign success     = success_q;

endmodule

// File: tb/tb_bomb_game_ctrl.sv
// tb/tb_bomb_game_ctrl.sv - directed self-checking bench for bomb_game_ctrl
module tb_bomb_game_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic Rst;

  logic       a_en, a_btn, a_tick, a_ok, a_bad;
  logic       a_bomb_en, a_showing, a_start, a_start_input;
  logic [4:0] a_random;
  logic [7:0] a_sec;
  logic [2:0] a_lives;
  logic       a_sub_rst_n, a_fail, a_success;

  logic       b_en, b_btn, b_tick, b_ok, b_bad;
  logic       b_bomb_en, b_showing, b_start, b_start_input;
  logic [7:0] b_random;
  logic [7:0] b_sec;
  logic [2:0] b_lives;
  logic       b_sub_rst_n, b_fail, b_success;

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;

  always @(posedge clk) cyc <= cyc + 1;

  bomb_game_ctrl u_dut_a (
    .clk         (clk),
    .Rst         (Rst),
    .enable      (a_en),
    .btn_start   (a_btn),
    .tick_1hz    (a_tick),
    .code_ok     (a_ok),
    .code_bad    (a_bad),
    .bomb_en     (a_bomb_en),
    .showing     (a_showing),
    .start       (a_start),
    .start_input (a_start_input),
    .random      (a_random),
    .sec_left    (a_sec),
    .lives       (a_lives),
    .sub_rst_n   (a_sub_rst_n),
    .fail        (a_fail),
    .success     (a_success)
  );

  bomb_game_ctrl #(
    .CODE_W       (8),
    .SEED         (8'hA5),
    .AUTO_RESTART (0)
  ) u_dut_b (
    .clk         (clk),
    .Rst         (Rst),
    .enable      (b_en),
    .btn_start   (b_btn),
    .tick_1hz    (b_tick),
    .code_ok     (b_ok),
    .code_bad    (b_bad),
    .bomb_en     (b_bomb_en),
    .showing     (b_showing),
    .start       (b_start),
    .start_input (b_start_input),
    .random      (b_random),
    .sec_left    (b_sec),
    .lives       (b_lives),
    .sub_rst_n   (b_sub_rst_n),
    .fail        (b_fail),
    .success     (b_success)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic tick_a();
    step(1);
    a_tick = 1'b1;
    step(1);
    a_tick = 1'b0;
  endtask

  task automatic tick_b();
    step(1);
    b_tick = 1'b1;
    step(1);
    b_tick = 1'b0;
  endtask

  task automatic bad_a();
    a_bad = 1'b1;
    step(1);
    a_bad = 1'b0;
  endtask

  task automatic press_a();
    a_btn = 1'b1;
    step(1);
    a_btn = 1'b0;
  endtask

  task automatic press_b();
    b_btn = 1'b1;
    step(1);
    b_btn = 1'b0;
  endtask

  logic [7:0] b_r1;
  int         b_c1;

  initial begin
    Rst = 1'b0;
    {a_en, a_btn, a_tick, a_ok, a_bad} = '0;
    {b_en, b_btn, b_tick, b_ok, b_bad} = '0;
    step(2);

    check("a_rst_random",  32'(a_random), 32'h15);
    check("a_rst_lives",   32'(a_lives), 32'd3);
    check("a_rst_sec",     32'(a_sec), 32'd0);
    check("a_rst_subrst",  32'(a_sub_rst_n), 32'd1);
    check("a_rst_enables", 32'({a_bomb_en, a_showing, a_start, a_start_input, a_fail, a_success}), 32'd0);
    check("b_rst_random",  32'(b_random), 32'hA5);

    Rst = 1'b1;
    step(1);
    check("a_off_subrst", 32'(a_sub_rst_n), 32'd1);
    a_en = 1'b1;
    step(1);
    check("a_idle_subrst_lo", 32'(a_sub_rst_n), 32'd0);
    check("a_idle_lives", 32'(a_lives), 32'd3);
    step(1);
    check("a_idle_subrst_hi", 32'(a_sub_rst_n), 32'd1);
    check("a_idle_bomb_en", 32'(a_bomb_en), 32'd0);

    // Round 1: show phase, then three wrong entries
    press_a();
    check("a_show_showing", 32'(a_showing), 32'd1);
    check("a_show_bomb_en", 32'(a_bomb_en), 32'd1);
    check("a_show_sec", 32'(a_sec), 32'd5);
    check("a_rand_nonzero", 32'(a_random != 5'd0), 32'd1);
    for (int i = 1; i <= 4; i++) begin
      tick_a();
      check("a_show_count", 32'(a_sec), 32'(5 - i));
      check("a_show_still", 32'(a_showing), 32'd1);
    end
    tick_a();
    check("a_in_showing", 32'(a_showing), 32'd0);
    check("a_in_enables", 32'({a_bomb_en, a_start, a_start_input}), 32'b111);
    check("a_in_sec", 32'(a_sec), 32'd20);
    bad_a();
    check("a_bad1_lives", 32'(a_lives), 32'd2);
    bad_a();
    check("a_bad2_lives", 32'(a_lives), 32'd1);
    check("a_bad2_input", 32'(a_start_input), 32'd1);
    bad_a();
    check("a_bad3_fail", 32'(a_fail), 32'd1);
    check("a_bad3_lives", 32'(a_lives), 32'd0);
    check("a_bad3_sec", 32'(a_sec), 32'd3);
    check("a_bad3_enables", 32'({a_bomb_en, a_start, a_start_input, a_showing}), 32'd0);
    tick_a();
    tick_a();
    check("a_hold_fail", 32'(a_fail), 32'd1);
    check("a_hold_sec", 32'(a_sec), 32'd1);
    tick_a();
    check("a_restart_fail", 32'(a_fail), 32'd0);
    check("a_restart_subrst", 32'(a_sub_rst_n), 32'd0);
    check("a_restart_lives", 32'(a_lives), 32'd3);
    step(1);
    check("a_restart_subrst_hi", 32'(a_sub_rst_n), 32'd1);

    // Round 2: let the entry timer run out
    press_a();
    repeat (5) tick_a();
    repeat (19) tick_a();
    check("a_to_sec1", 32'(a_sec), 32'd1);
    check("a_to_start", 32'(a_start), 32'd1);
    tick_a();
    check("a_to_fail", 32'(a_fail), 32'd1);
    check("a_to_start_off", 32'(a_start), 32'd0);
    repeat (3) tick_a();
    check("a_to_idle_subrst", 32'(a_sub_rst_n), 32'd0);

    // Round 3: correct code on the same cycle as the last tick
    step(1);
    press_a();
    repeat (5) tick_a();
    step(1);
    press_a();
    check("a_in_ignore_start", 32'(a_start), 32'd1);
    check("a_in_ignore_sec", 32'(a_sec), 32'd20);
    repeat (19) tick_a();
    step(1);
    a_tick = 1'b1;
    a_ok   = 1'b1;
    step(1);
    a_tick = 1'b0;
    a_ok   = 1'b0;
    check("a_ok_tie_success", 32'(a_success), 32'd1);
    check("a_ok_tie_fail", 32'(a_fail), 32'd0);
    check("a_ok_tie_showing", 32'(a_showing), 32'd1);
    check("a_ok_tie_bomb_en", 32'(a_bomb_en), 32'd0);
    repeat (3) tick_a();
    check("a_succ_idle", 32'(a_success), 32'd0);
    check("a_succ_idle_subrst", 32'(a_sub_rst_n), 32'd0);

    // Master switch dropped in the middle of the show phase
    step(1);
    press_a();
    tick_a();
    check("a_show_mid_sec", 32'(a_sec), 32'd4);
    a_en = 1'b0;
    step(1);
    check("a_off_showing", 32'(a_showing), 32'd0);
    check("a_off_bomb_en", 32'(a_bomb_en), 32'd0);
    check("a_off_subrst_lo", 32'(a_sub_rst_n), 32'd0);
    check("a_off_lives", 32'(a_lives), 32'd3);
    step(1);
    check("a_off_subrst_hi", 32'(a_sub_rst_n), 32'd1);
    a_en = 1'b1;
    step(1);
    check("a_reen_subrst_lo", 32'(a_sub_rst_n), 32'd0);
    step(1);
    check("a_reen_subrst_hi", 32'(a_sub_rst_n), 32'd1);

    // Non-auto instance, 8-bit code
    b_en = 1'b1;
    step(1);
    check("b_idle_subrst", 32'(b_sub_rst_n), 32'd0);
    step(1);
    b_c1 = cyc;
    press_b();
    b_r1 = b_random;
    check("b_show_showing", 32'(b_showing), 32'd1);
    repeat (5) tick_b();
    check("b_in_sec", 32'(b_sec), 32'd20);
    b_ok = 1'b1;
    step(1);
    b_ok = 1'b0;
    check("b_success", 32'(b_success), 32'd1);
    check("b_success_sec", 32'(b_sec), 32'd3);
    repeat (3) tick_b();
    check("b_wait_sec", 32'(b_sec), 32'd0);
    check("b_wait_success", 32'(b_success), 32'd1);
    tick_b();
    step(5);
    check("b_wait_still", 32'(b_success), 32'd1);
    check("b_wait_sec0", 32'(b_sec), 32'd0);
    press_b();
    check("b_wait_exit", 32'(b_success), 32'd0);
    check("b_wait_subrst", 32'(b_sub_rst_n), 32'd0);
    step(1);
    // A gap that is a multiple of the LFSR period would latch the same code
    while (((cyc - b_c1) % 255) == 0) step(1);
    press_b();
    check("b_r2_showing", 32'(b_showing), 32'd1);
    check("b_r2_sec", 32'(b_sec), 32'd5);
    check("b_r2_differs", 32'(b_random != b_r1), 32'd1);
    check("b_r2_nonzero", 32'(b_random != 8'd0), 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
